// File: rtl/hazard_pkg.sv
// Shared types and constants for the hazard stall controller and its occupancy counter.
package hazard_pkg;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} hz_state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

    localparam int DEFAULT_MUL_LATENCY = 3;
    localparam int DEFAULT_DIV_LATENCY = 32;

endpackage

// File: rtl/hazard_stall_controller_muldiv_occupancy_counter.sv
// Down-counter tracking how many more E-stage cycles a mul/div occupies; flags the last BUSY cycle.
module muldiv_occupancy_counter #(
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             tc_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // A load always wins; decrementing stops at zero so the count can never wrap.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (dec_i && (count_q != '0)) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc_o = (count_q == CNT_W'(1));

endmodule

// File: rtl/hazard_stall_controller.sv
// Load-use / mul-div / branch hazard sequencer for the 5-stage core.
// Optional HAZARD_PERF_CNT_EN adds a saturating count of cycles with stall_f high.
module hazard_stall_controller
    import hazard_pkg::*;
#(
    parameter int MUL_LATENCY = DEFAULT_MUL_LATENCY,
    parameter int DIV_LATENCY = DEFAULT_DIV_LATENCY,
    parameter int CNT_W       = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  reg_readaddress1_d,
    input  logic [4:0]  reg_readaddress2_d,
    input  logic [4:0]  reg_writeaddress_e,
    input  logic        mem_read_e,
    input  logic        muldiv_start_e,
    input  logic        muldiv_is_div_e,
    input  logic        branch_taken_e,
    output logic        stall_f,
    output logic        stall_d,
    output logic        stall_e,
    output logic        flush_d,
    output logic        flush_e,
    output logic        bubble_m,
    output logic        muldiv_go,
    output logic        muldiv_done
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0] perf_stall_cycles
`endif
);

    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LATENCY - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LATENCY - 1);

    hz_state_t        state_q;
    logic             loadUse;
    logic             launch;
    logic             cntTc;
    logic [CNT_W-1:0] cntLoadVal;

    assign loadUse = mem_read_e && (reg_writeaddress_e != REG_ZERO) &&
                     ((reg_writeaddress_e == reg_readaddress1_d) ||
                      (reg_writeaddress_e == reg_readaddress2_d));

    // A start seen in DONE is deliberately not launched; it goes out the following IDLE cycle.
    assign launch     = (state_q == IDLE) && !branch_taken_e && muldiv_start_e;
    assign cntLoadVal = muldiv_is_div_e ? DIV_LOAD : MUL_LOAD;

    muldiv_occupancy_counter #(
        .CNT_W(CNT_W)
    ) u_occupancy (
        .clk       (clk),
        .rst       (rst),
        .load_i    (launch),
        .load_val_i(cntLoadVal),
        .dec_i     (state_q == BUSY),
        .tc_o      (cntTc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            case (state_q)
                IDLE:    if (launch) state_q <= BUSY;
                BUSY:    if (cntTc)  state_q <= DONE;
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // Outputs are forced low while rst is high so an abort is visible without waiting for an edge.
    always_comb begin
        stall_f     = 1'b0;
        stall_d     = 1'b0;
        stall_e     = 1'b0;
        flush_d     = 1'b0;
        flush_e     = 1'b0;
        bubble_m    = 1'b0;
        muldiv_go   = 1'b0;
        muldiv_done = 1'b0;
        if (!rst) begin
            case (state_q)
                IDLE: begin
                    if (branch_taken_e) begin
                        flush_d = 1'b1;
                        flush_e = 1'b1;
                    end else if (muldiv_start_e) begin
                        muldiv_go = 1'b1;
                        stall_f   = 1'b1;
                        stall_d   = 1'b1;
                        stall_e   = 1'b1;
                        bubble_m  = 1'b1;
                    end else if (loadUse) begin
                        stall_f = 1'b1;
                        stall_d = 1'b1;
                        flush_e = 1'b1;
                    end
                end
                BUSY: begin
                    stall_f  = 1'b1;
                    stall_d  = 1'b1;
                    stall_e  = 1'b1;
                    bubble_m = 1'b1;
                end
                DONE: begin
                    muldiv_done = 1'b1;
                    if (branch_taken_e) begin
                        flush_d = 1'b1;
                        flush_e = 1'b1;
                    end else if (loadUse) begin
                        stall_f = 1'b1;
                        stall_d = 1'b1;
                        flush_e = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] perf_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_q <= '0;
        end else if (stall_f && (perf_q != 32'hFFFF_FFFF)) begin
            perf_q <= perf_q + 32'd1;
        end
    end

    assign perf_stall_cycles = perf_q;
`endif

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Scoreboard bench for hazard_stall_controller; also covers HAZARD_PERF_CNT_EN when defined.
module tb_hazard_stall_controller;

    localparam int MUL_LAT = 3;
    localparam int DIV_LAT = 32;

    // Output vector bit order: stall_f stall_d stall_e flush_d flush_e bubble_m muldiv_go muldiv_done
    localparam logic [7:0] VEC_BUSY    = 8'b1110_0100;
    localparam logic [7:0] VEC_LAUNCH  = 8'b1110_0110;
    localparam logic [7:0] VEC_LOADUSE = 8'b1100_1000;
    localparam logic [7:0] VEC_BRANCH  = 8'b0001_1000;

    typedef struct {
        logic [7:0] vec;
        string      tag;
    } sb_entry_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] rs1, rs2, rdE;
    logic       memRd, mdStart, mdIsDiv, brTaken;
    logic       stall_f, stall_d, stall_e, flush_d, flush_e, bubble_m, muldiv_go, muldiv_done;
    logic [7:0] outVec;
    logic [7:0] lastVec;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] perfStall;
`endif

    sb_entry_t sbQ[$];
    int vecCount  = 0;
    int missCount = 0;
    int mBusy     = 0;
    bit mDone     = 1'b0;
    int mPerf     = 0;
    int stallECnt;

    always #5 clk = ~clk;

    assign outVec = {stall_f, stall_d, stall_e, flush_d, flush_e, bubble_m, muldiv_go, muldiv_done};

    hazard_stall_controller #(
        .MUL_LATENCY(MUL_LAT),
        .DIV_LATENCY(DIV_LAT),
        .CNT_W      (6)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .reg_readaddress1_d(rs1),
        .reg_readaddress2_d(rs2),
        .reg_writeaddress_e(rdE),
        .mem_read_e        (memRd),
        .muldiv_start_e    (mdStart),
        .muldiv_is_div_e   (mdIsDiv),
        .branch_taken_e    (brTaken),
        .stall_f           (stall_f),
        .stall_d           (stall_d),
        .stall_e           (stall_e),
        .flush_d           (flush_d),
        .flush_e           (flush_e),
        .bubble_m          (bubble_m),
        .muldiv_go         (muldiv_go),
        .muldiv_done       (muldiv_done)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .perf_stall_cycles (perfStall)
`endif
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        vecCount++;
        if (actual !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Called just after a rising edge: drive one cycle of inputs, predict, sample at the falling edge.
    task automatic applyStimulus(input string tag, input logic br, input logic st, input logic dv,
                                 input logic mr, input logic [4:0] rd, input logic [4:0] r1,
                                 input logic [4:0] r2);
        logic [7:0] expVec;
        logic       hit;
        bit         nextDone;
        sb_entry_t  entry;
        brTaken = br;
        mdStart = st;
        mdIsDiv = dv;
        memRd   = mr;
        rdE     = rd;
        rs1     = r1;
        rs2     = r2;
        expVec   = '0;
        nextDone = 1'b0;
        hit      = mr && (rd != 5'd0) && ((rd == r1) || (rd == r2));
        if (mBusy > 0) begin
            expVec   = VEC_BUSY;
            nextDone = (mBusy == 1);
            mBusy--;
        end else begin
            if (mDone) expVec[0] = 1'b1;
            if (br) begin
                expVec |= VEC_BRANCH;
            end else if (st && !mDone) begin
                expVec |= VEC_LAUNCH;
                mBusy = (dv ? DIV_LAT : MUL_LAT) - 1;
            end else if (hit) begin
                expVec |= VEC_LOADUSE;
            end
        end
        mDone = nextDone;
        if (expVec[7]) mPerf++;
        entry.vec = expVec;
        entry.tag = tag;
        sbQ.push_back(entry);
        @(negedge clk);
        entry   = sbQ.pop_front();
        lastVec = outVec;
        checkOutput(entry.tag, {24'd0, outVec}, {24'd0, entry.vec});
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst     = 1'b1;
        brTaken = 1'b1;
        mdStart = 1'b1;
        mdIsDiv = 1'b0;
        memRd   = 1'b1;
        rdE     = 5'd5;
        rs1     = 5'd0;
        rs2     = 5'd5;
        @(posedge clk);
        #1;
        checkOutput("reset_outputs", {24'd0, outVec}, 32'd0);
`ifdef HAZARD_PERF_CNT_EN
        checkOutput("reset_perf", perfStall, 32'd0);
`endif
        rst = 1'b0;

        applyStimulus("idle_quiet",  0, 0, 0, 0, 5'd0, 5'd0, 5'd0);

        applyStimulus("mul_launch",  0, 1, 0, 0, 5'd0, 5'd0, 5'd0);
        applyStimulus("mul_busy",    0, 1, 0, 0, 5'd0, 5'd0, 5'd0);
        applyStimulus("mul_busy",    0, 1, 0, 0, 5'd0, 5'd0, 5'd0);
        applyStimulus("mul_done",    0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
        applyStimulus("loaduse_rs2", 0, 0, 0, 1, 5'd5, 5'd1, 5'd5);
        applyStimulus("after_lu",    0, 0, 0, 0, 5'd0, 5'd1, 5'd5);
`ifdef HAZARD_PERF_CNT_EN
        checkOutput("perf_mul_plus_lu", perfStall, 32'd4);
`endif

        applyStimulus("loaduse_rs1", 0, 0, 0, 1, 5'd7, 5'd7, 5'd2);
        applyStimulus("x0_no_stall", 0, 0, 0, 1, 5'd0, 5'd0, 5'd0);
        applyStimulus("no_load",     0, 0, 0, 0, 5'd7, 5'd7, 5'd7);
        applyStimulus("lu_nomatch",  0, 0, 0, 1, 5'd8, 5'd7, 5'd9);
        applyStimulus("branch",      0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
        applyStimulus("branch",      1, 0, 0, 0, 5'd0, 5'd0, 5'd0);

        applyStimulus("priority",    1, 1, 0, 1, 5'd4, 5'd4, 5'd4);
        applyStimulus("prio_after",  0, 0, 0, 0, 5'd0, 5'd0, 5'd0);

        stallECnt = 0;
        applyStimulus("div_launch",  0, 1, 1, 0, 5'd0, 5'd0, 5'd0);
        if (lastVec[5]) stallECnt++;
        for (int c = 2; c <= DIV_LAT; c++) begin
            applyStimulus("div_busy", (c == 10), 1, 1, (c == 20), 5'd9, 5'd9, 5'd0);
            if (lastVec[5]) stallECnt++;
        end
        applyStimulus("div_done",    0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
        if (lastVec[5]) stallECnt++;
        checkOutput("div_stall_e_cycles", stallECnt, DIV_LAT);
        checkOutput("div_done_strobe", {31'd0, lastVec[0]}, 32'd1);

        applyStimulus("b2b_launch",  0, 1, 0, 0, 5'd0, 5'd0, 5'd0);
        applyStimulus("b2b_busy",    0, 1, 0, 0, 5'd0, 5'd0, 5'd0);
        applyStimulus("b2b_busy",    0, 1, 0, 0, 5'd0, 5'd0, 5'd0);
        applyStimulus("b2b_done_lu", 0, 1, 0, 1, 5'd3, 5'd3, 5'd0);
        applyStimulus("b2b_relaunch",0, 1, 0, 0, 5'd0, 5'd0, 5'd0);
        applyStimulus("b2b_busy",    0, 1, 0, 0, 5'd0, 5'd0, 5'd0);
        applyStimulus("b2b_busy",    0, 1, 0, 0, 5'd0, 5'd0, 5'd0);
        applyStimulus("done_branch", 1, 0, 0, 0, 5'd0, 5'd0, 5'd0);
        applyStimulus("b2b_idle",    0, 0, 0, 0, 5'd0, 5'd0, 5'd0);

        applyStimulus("rdiv_launch", 0, 1, 1, 0, 5'd0, 5'd0, 5'd0);
        for (int c = 2; c <= 4; c++) begin
            applyStimulus("rdiv_busy", 0, 1, 1, 0, 5'd0, 5'd0, 5'd0);
        end
        brTaken = 1'b1;
        memRd   = 1'b1;
        rdE     = 5'd6;
        rs1     = 5'd6;
        #3;
        rst = 1'b1;
        #1;
        checkOutput("rst_async_outputs", {24'd0, outVec}, 32'd0);
        mBusy = 0;
        mDone = 1'b0;
        mPerf = 0;
        sbQ.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        applyStimulus("post_rst_idle", 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
        applyStimulus("post_rst_idle", 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
        applyStimulus("post_rst_lu",   0, 0, 0, 1, 5'd6, 5'd0, 5'd6);
        applyStimulus("post_rst_mul",  0, 1, 0, 0, 5'd0, 5'd0, 5'd0);
        applyStimulus("post_rst_busy", 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
        applyStimulus("post_rst_busy", 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
        applyStimulus("post_rst_done", 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
        applyStimulus("post_rst_end",  0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
`ifdef HAZARD_PERF_CNT_EN
        checkOutput("perf_final", perfStall, mPerf);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule

// File: doc/hazard_stall_controller.md
Name: hazard_stall_controller

Overview:
- Pipeline hazard sequencer for the 5-stage RISC-V core. It sits beside the E-stage operand forwarding logic.
- Covers the hazards that forwarding cannot resolve:
  - load-use dependencies (1-cycle bubble);
  - multi-cycle multiply/divide occupancy of the E stage (stall N cycles);
  - taken-branch redirects (flush D/E).
- Drives stall/flush enables for the F/D/E/M pipeline registers and the start/done sequencing of the mul/div unit.

Parameters:
- MUL_LATENCY, 3, total E-stage cycles a multiply occupies (>=2)
- DIV_LATENCY, 32, total E-stage cycles a divide occupies (>=2)
- CNT_W, 6, width of the occupancy counter (must hold max(MUL_LATENCY, DIV_LATENCY)-1)

Ports:
- clk  input  1  core clock, rising edge
- rst  input  1  asynchronous reset, active-high
- reg_readaddress1_d  input  5  rs1 of the instruction in D
- reg_readaddress2_d  input  5  rs2 of the instruction in D
- reg_writeaddress_e  input  5  rd of the instruction in E
- mem_read_e  input  1  E instruction is a load
- muldiv_start_e  input  1  E instruction is a mul/div (level, valid in E)
- muldiv_is_div_e  input  1  1 = divide, 0 = multiply; qualifies muldiv_start_e
- branch_taken_e  input  1  E-stage branch/jump resolved taken
- stall_f  output  1  hold PC
- stall_d  output  1  hold F/D register
- stall_e  output  1  hold D/E register and E-stage operands
- flush_d  output  1  clear F/D to NOP
- flush_e  output  1  clear D/E to NOP
- bubble_m  output  1  insert NOP into E/M
- muldiv_go  output  1  1-cycle launch pulse to the mul/div unit
- muldiv_done  output  1  1-cycle result-valid strobe; E/M captures the result

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset state: FSM = IDLE, counter = 0, all outputs 0.
  - rst asserted mid-operation aborts any BUSY sequence immediately.
  - After reset deassertion, the first cycle is IDLE.
- FSM states: IDLE, BUSY, DONE.
- IDLE, priority high to low:
  1. branch_taken_e=1 → flush_d=1, flush_e=1, no stalls; ignore muldiv_start_e/load-use this cycle; stay IDLE.
  2. muldiv_start_e=1 → muldiv_go=1, stall_f=stall_d=stall_e=1, bubble_m=1; counter ← LAT-1, where LAT = muldiv_is_div_e ? DIV_LATENCY : MUL_LATENCY; next state BUSY.
  3. Load-use: mem_read_e=1 and reg_writeaddress_e≠0 and (reg_writeaddress_e==reg_readaddress1_d or reg_writeaddress_e==reg_readaddress2_d) → stall_f=stall_d=1, flush_e=1; stay IDLE. Pure combinational, exactly 1 bubble.
  4. Otherwise all outputs 0.
- BUSY:
  - stall_f=stall_d=stall_e=1, bubble_m=1; branch_taken_e and load-use inputs are ignored.
  - Counter==1 → next state DONE; else counter-1.
- DONE (1 cycle):
  - muldiv_done=1; all stalls 0; counter=0; next state IDLE.
  - A load-use or branch presented in DONE is evaluated as in IDLE.
- Cycle totals: stall_e is high for exactly LAT consecutive cycles (launch cycle + LAT-1 BUSY cycles). muldiv_done follows in cycle LAT+1.
- Registers: x0 never triggers load-use.
- Stall and flush of the same stage are never both asserted.
- Back-to-back mul/div: the next muldiv_start_e seen in DONE is not launched. It is launched in the following IDLE cycle.
- Counter arithmetic: unsigned, never underflows. The LAT-1 load is truncated to CNT_W; CNT_W must be sized accordingly.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- When defined: adds output perf_stall_cycles (32 bits).
  - Increments in every cycle with stall_f=1; saturates at 0xFFFF_FFFF.
  - Reset to 0 by rst.
- When undefined: the port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Shared package hazard_pkg:
  - typedef enum logic [1:0] {IDLE, BUSY, DONE} hz_state_t;
  - REG_ZERO = 5'd0;
  - default MUL_LATENCY and DIV_LATENCY constants.
- One sub-module, muldiv_occupancy_counter: load/decrement/terminal-count flag, CNT_W wide.
- The FSM and hazard compare logic live in the top module.

Test Plan:
- Load-use:
  - Stimulus: mem_read_e=1, reg_writeaddress_e=5, reg_readaddress2_d=5.
  - Expect: stall_f=stall_d=flush_e=1 for 1 cycle. With reg_writeaddress_e=0 and both sources 0: no stall.
- Multiply:
  - Stimulus: muldiv_start_e=1, is_div=0, MUL_LATENCY=3.
  - Expect: muldiv_go 1 cycle; stall_e high cycles 1-3; muldiv_done=1 in cycle 4; stalls low in cycle 4.
- Divide:
  - Stimulus: is_div=1, DIV_LATENCY=32.
  - Expect: stall_e high exactly 32 cycles. A branch_taken_e=1 pulse at cycle 10 produces no flush.
- Priority:
  - Stimulus: branch_taken_e=1 with load-use match and muldiv_start_e=1 in IDLE.
  - Expect: flush_d=flush_e=1, no stalls, muldiv_go=0, state stays IDLE.
- Reset mid-divide:
  - Stimulus: assert rst at cycle 5 of a divide, asynchronously between edges.
  - Expect: all outputs 0 immediately; after release, IDLE with no muldiv_done.
- HAZARD_PERF_CNT_EN defined:
  - Stimulus: one multiply (LAT=3) plus one load-use.
  - Expect: perf_stall_cycles=4.
